seq_divider16: RTL and testbench

- Multi-cycle restoring divider, one quotient bit per clock.
- Sits downstream of the operand input-register stage: consumes registered A/B operands and produces quotient and remainder.
- Its results feed the output mux and accumulator path.
- Replaces the single-cycle combinational divide, which does not fit the cycle budget; uses a start/busy/done handshake.

---
 rtl/seq_divider16.sv | 193 +++++++++++++++++++
 tb/tb_seq_divider16.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider16.sv
// -----------------------------------------------------------------------------
// seq_divider16
//   Multi-cycle restoring divider that produces one quotient bit per clock.
//   It takes the registered A/B operands and returns the quotient and the
//   remainder. Operations use a start/busy/done handshake.
//
//   Latency: a start accepted at edge T raises done in the cycle after edge
//   T+N, which is N+1 cycles in total. A divide by zero raises done in the
//   cycle after the accepting edge.
//
//   Optional build macro SEQ_DIVIDER16_SIGNED_EN:
//     When defined, a and b are treated as two's complement and the result
//     truncates toward zero. When undefined, the divider is unsigned only and
//     no sign logic is built.
//
// Ports:
//   clk          system clock; all state updates on its rising edge
//   rst          synchronous active-high reset; takes priority over start
//   start        request; accepted on a rising edge while busy=0
//   a [N-1:0]    dividend, sampled when start is accepted
//   b [N-1:0]    divisor, sampled when start is accepted
//   busy         high while iterating; start is ignored while busy is high
//   done         single-cycle pulse; results are valid in that cycle
//   quotient     result quotient, held until the next completion
//   remainder    result remainder, held until the next completion
//   div_by_zero  set together with done when the sampled b was 0
// -----------------------------------------------------------------------------
module seq_divider16 #(
  parameter int N  = 16,
  parameter int CW = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   qreg_q, qreg_d;        // dividend shifting out / quotient shifting in
  logic [N:0]     prem_q, prem_d;        // partial remainder, one guard bit
  logic [N-1:0]   divisor_q, divisor_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;
`ifdef SEQ_DIVIDER16_SIGNED_EN
  logic           sgn_quo_q, sgn_quo_d;
  logic           sgn_rem_q, sgn_rem_d;
`endif

  // One restoring step, computed from the current work registers.
  logic [N:0]     prem_sh;
  logic [N:0]     trial;
  logic [N:0]     prem_step;
  logic [N-1:0]   q_step;
  logic [N-1:0]   quo_fin;
  logic [N-1:0]   rem_fin;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;

  always_comb begin
    prem_sh = {prem_q[N-1:0], qreg_q[N-1]};
    trial   = prem_sh - {1'b0, divisor_q};
    if (!trial[N]) begin
      prem_step = trial;
      q_step    = {qreg_q[N-2:0], 1'b1};
    end else begin
      prem_step = prem_sh;
      q_step    = {qreg_q[N-2:0], 1'b0};
    end

    // The partial remainder is always below the divisor, so N bits hold it.
    quo_fin = q_step;
    rem_fin = prem_step[N-1:0];
`ifdef SEQ_DIVIDER16_SIGNED_EN
    if (sgn_quo_q) quo_fin = -q_step;
    if (sgn_rem_q) rem_fin = -prem_step[N-1:0];
    // The magnitude of the most negative value is 1 followed by zeros, which
    // is still correct when read as an unsigned number.
    a_mag = a[N-1] ? -a : a;
    b_mag = b[N-1] ? -b : b;
`else
    a_mag = a;
    b_mag = b;
`endif
  end

  always_comb begin
    state_d   = state_q;
    qreg_d    = qreg_q;
    prem_d    = prem_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
`ifdef SEQ_DIVIDER16_SIGNED_EN
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
`endif

    case (state_q)
      S_RUN: begin
        qreg_d = q_step;
        prem_d = prem_step;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // The last step writes its result straight into the output registers.
          state_d = S_DONE;
          quo_d   = quo_fin;
          rem_d   = rem_fin;
          dbz_d   = 1'b0;
        end
      end

      S_IDLE, S_DONE: begin
        // DONE accepts a new start as well, so that start held high
        // back-to-back never passes through IDLE.
        state_d = S_IDLE;
        if (start) begin
          if (b == '0) begin
            // Divide by zero finishes at once; the remainder is the raw a.
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = a;
            dbz_d   = 1'b1;
          end else begin
            state_d   = S_RUN;
            qreg_d    = a_mag;
            divisor_d = b_mag;
            prem_d    = '0;
            cnt_d     = CW'(N);
`ifdef SEQ_DIVIDER16_SIGNED_EN
            sgn_quo_d = a[N-1] ^ b[N-1];
            sgn_rem_d = a[N-1];
`endif
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      qreg_q    <= '0;
      prem_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
`ifdef SEQ_DIVIDER16_SIGNED_EN
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      qreg_q    <= qreg_d;
      prem_q    <= prem_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
`ifdef SEQ_DIVIDER16_SIGNED_EN
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
`endif
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider16.sv
// -----------------------------------------------------------------------------
// tb_seq_divider16
//   Scoreboard bench for seq_divider16. A transaction-level model decides
//   which starts are accepted, works out each result with plain arithmetic and
//   queues it together with the cycle in which done is due. A separate monitor
//   checks done, busy and the held outputs every cycle against that queue.
// -----------------------------------------------------------------------------
module tb_seq_divider16;
  localparam int N  = 16;
  localparam int CW = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  always #5 clk = ~clk;

  seq_divider16 #(.N(N), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    int           done_edge;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           free_edge = 0;
  int           run_lo = 1;
  int           run_hi = 0;
  int           txn = 0;
  bit           armed = 1'b0;
  logic [N-1:0] hold_q = '0;
  logic [N-1:0] hold_r = '0;
  logic         hold_z = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference result computed from the arithmetic definition.
  function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv);
    exp_t e;
    int   sa, sb_i, tq, tr;
    e.a = av;
    e.b = bv;
    e.done_edge = 0;
    if (bv == '0) begin
      e.q = '1;
      e.r = av;
      e.z = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER16_SIGNED_EN
      sa   = int'($signed(av));
      sb_i = int'($signed(bv));
`else
      sa   = int'({16'd0, av});
      sb_i = int'({16'd0, bv});
`endif
      tq  = sa / sb_i;
      tr  = sa % sb_i;
      e.q = tq[N-1:0];
      e.r = tr[N-1:0];
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Transaction model: acceptance, latency and reset behaviour.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      sb.delete();
      free_edge = cyc + 1;
      run_lo = 1;
      run_hi = 0;
      hold_q = '0;
      hold_r = '0;
      hold_z = 1'b0;
      armed  = 1'b1;
    end else if (armed && start && cyc >= free_edge) begin
      e = model(a, b);
      if (b == '0) begin
        e.done_edge = cyc;
        free_edge   = cyc + 1;
      end else begin
        e.done_edge = cyc + N;
        run_lo      = cyc;
        run_hi      = cyc + N - 1;
        free_edge   = cyc + N + 1;
      end
      sb.push_back(e);
    end
  end

  // Monitor: compares the DUT against the model once per cycle.
  always @(negedge clk) begin
    exp_t e;
    logic exp_done, exp_busy;
    if (armed) begin
      exp_done = (sb.size() > 0) && (sb[0].done_edge == cyc);
      exp_busy = (cyc >= run_lo) && (cyc <= run_hi);
      chk("done", {31'd0, done}, {31'd0, exp_done});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      if (exp_done) begin
        e = sb.pop_front();
        hold_q = e.q;
        hold_r = e.r;
        hold_z = e.z;
        txn++;
        $display("txn %0d cycle %0d: a=%h b=%h -> q=%h r=%h dbz=%b (expect q=%h r=%h dbz=%b)",
                 txn, cyc, e.a, e.b, quotient, remainder, div_by_zero, e.q, e.r, e.z);
      end
      chk("quotient", {16'd0, quotient}, {16'd0, hold_q});
      chk("remainder", {16'd0, remainder}, {16'd0, hold_r});
      chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, hold_z});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic op(input logic [N-1:0] av, input logic [N-1:0] bv);
    start = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int r;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Directed cases.
    op(16'd100, 16'd7);        idle(20);
    op(16'hFFFF, 16'd1);       idle(18);
    op(16'hFFFF, 16'hFFFF);    idle(18);
    op(16'd5, 16'd0);          idle(3);
    op(16'd100, 16'd7);        idle(20);
    op(16'hFFF9, 16'd2);       idle(18);
    op(16'd7, 16'hFFFE);       idle(18);
    op(16'h8000, 16'hFFFF);    idle(18);
    op(16'h8000, 16'd1);       idle(18);

    // A start while busy is ignored; a start held into the done cycle is
    // accepted back-to-back.
    op(16'd100, 16'd7);
    idle(3);
    start = 1'b1;
    a = 16'd9;
    b = 16'd3;
    idle(14);
    start = 1'b0;
    idle(20);

    // Start held high continuously.
    start = 1'b1;
    a = 16'd1234;
    b = 16'd37;
    idle(40);
    start = 1'b0;
    idle(20);

    // Reset in the middle of an operation, then a normal operation.
    op(16'd200, 16'd3);
    idle(7);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    op(16'd10, 16'd4);
    idle(20);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 3) == 0;
      a = 16'($urandom);
      r = int'($urandom % 8);
      if (r == 0)      b = '0;
      else if (r == 1) b = 16'($urandom % 16);
      else             b = 16'($urandom);
      rst = ($urandom % 400) == 0;
      @(negedge clk);
    end
    start = 1'b0;
    rst = 1'b0;
    idle(40);

    chk("drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
